// File: rtl/window_stat_sched_if.sv
// Bundles the job-control, stats-unit and result ports of the window statistics sequencer.
// master is the sequencer side; slave is the controller/stats/consumer side.
interface window_stat_sched_if #(
    parameter int WIDTH = 32
);
    logic             go;
    logic [WIDTH-1:0] cfg_len;
    logic [WIDTH-1:0] cfg_win;
    logic [WIDTH-1:0] cfg_stride;
    logic             busy;
    logic             finished;
    logic             cfg_err;
    logic             stat_start;
    logic [WIDTH-1:0] stat_si;
    logic [WIDTH-1:0] stat_ei;
    logic             stat_done;
    logic [WIDTH-1:0] stat_mean;
    logic [WIDTH-1:0] stat_variance;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_mean;
    logic [WIDTH-1:0] res_variance;
    logic [WIDTH-1:0] res_idx;
    logic             res_last;

    modport master (
        input  go, cfg_len, cfg_win, cfg_stride, stat_done, stat_mean, stat_variance, res_ready,
        output busy, finished, cfg_err, stat_start, stat_si, stat_ei,
               res_valid, res_mean, res_variance, res_idx, res_last
    );

    modport slave (
        output go, cfg_len, cfg_win, cfg_stride, stat_done, stat_mean, stat_variance, res_ready,
        input  busy, finished, cfg_err, stat_start, stat_si, stat_ei,
               res_valid, res_mean, res_variance, res_idx, res_last
    );
endinterface

// File: rtl/window_stat_sched.sv
// Walks a series in sliding windows, launching the stats unit per window and emitting results.
// Start: go -> stat_start next cycle; stat_done -> res_valid next cycle; no new window while res_ready is low.
module window_stat_sched #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 1024
) (
    input logic                 Clk,
    input logic                 Rst,
    window_stat_sched_if.master bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LAUNCH = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_EMIT   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    logic [2:0]       state;
    logic [WIDTH-1:0] len_q, win_q, stride_q;
    logic [WIDTH-1:0] si_q, ei_q, idx_q;
    logic [TW-1:0]    tcnt;
    logic             busy_q, finished_q, cfg_err_q, start_q;
    logic             res_valid_q, res_last_q;
    logic [WIDTH-1:0] res_mean_q, res_var_q, res_idx_q;

    logic             cfg_bad;
    logic [WIDTH:0]   next_end;
    logic [WIDTH-1:0] next_si;

    assign cfg_bad  = (bus.cfg_win == '0) || (bus.cfg_stride == '0) || (bus.cfg_win > bus.cfg_len);
    // One extra bit so a start+stride+window that wraps WIDTH still reads as past the end.
    assign next_end = {1'b0, si_q} + {1'b0, stride_q} + {1'b0, win_q};
    assign next_si  = si_q + stride_q;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state       <= S_IDLE;
            len_q       <= '0;
            win_q       <= '0;
            stride_q    <= '0;
            si_q        <= '0;
            ei_q        <= '0;
            idx_q       <= '0;
            tcnt        <= '0;
            busy_q      <= 1'b0;
            finished_q  <= 1'b0;
            cfg_err_q   <= 1'b0;
            start_q     <= 1'b0;
            res_valid_q <= 1'b0;
            res_last_q  <= 1'b0;
            res_mean_q  <= '0;
            res_var_q   <= '0;
            res_idx_q   <= '0;
        end else begin
            finished_q <= 1'b0;
            cfg_err_q  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.go) begin
                        if (cfg_bad) begin
                            cfg_err_q <= 1'b1;
                        end else begin
                            len_q    <= bus.cfg_len;
                            win_q    <= bus.cfg_win;
                            stride_q <= bus.cfg_stride;
                            si_q     <= '0;
                            ei_q     <= bus.cfg_win;
                            idx_q    <= '0;
                            start_q  <= 1'b1;
                            busy_q   <= 1'b1;
                            state    <= S_LAUNCH;
                        end
                    end
                end
                S_LAUNCH: begin
                    start_q <= 1'b0;
                    tcnt    <= '0;
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.stat_done) begin
                        res_mean_q  <= bus.stat_mean;
                        res_var_q   <= bus.stat_variance;
                        res_idx_q   <= idx_q;
                        res_last_q  <= (next_end > {1'b0, len_q});
                        res_valid_q <= 1'b1;
                        state       <= S_EMIT;
                    end else if (tcnt == TLAST) begin
                        cfg_err_q <= 1'b1;
                        busy_q    <= 1'b0;
                        state     <= S_IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                S_EMIT: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        if (res_last_q) begin
                            finished_q <= 1'b1;
                            state      <= S_DONE;
                        end else begin
                            si_q    <= next_si;
                            ei_q    <= next_end[WIDTH-1:0];
                            idx_q   <= idx_q + 1'b1;
                            start_q <= 1'b1;
                            state   <= S_LAUNCH;
                        end
                    end
                end
                S_DONE: begin
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy         = busy_q;
    assign bus.finished     = finished_q;
    assign bus.cfg_err      = cfg_err_q;
    assign bus.stat_start   = start_q;
    assign bus.stat_si      = si_q;
    assign bus.stat_ei      = ei_q;
    assign bus.res_valid    = res_valid_q;
    assign bus.res_mean     = res_mean_q;
    assign bus.res_variance = res_var_q;
    assign bus.res_idx      = res_idx_q;
    assign bus.res_last     = res_last_q;
endmodule

// File: tb/tb_window_stat_sched.sv
// Directed vector bench for window_stat_sched with a latency-programmable stats-unit model.
module tb_window_stat_sched;
    localparam int WD = 32;
    localparam int TO = 16;

    logic Clk = 1'b0;
    logic Rst;
    always #5 Clk = ~Clk;

    window_stat_sched_if #(.WIDTH(WD)) bus ();
    window_stat_sched #(.WIDTH(WD), .TIMEOUT(TO)) dut (.Clk(Clk), .Rst(Rst), .bus(bus));

    // kind: 0 normal job, 1 rejected config, 2 timeout
    typedef struct {
        logic [31:0] len;
        logic [31:0] win;
        logic [31:0] stride;
        int          lat;
        int          stall;
        bit          go_mid;
        int          kind;
        int          exp_res;
        int          exp_starts;
    } vec_t;

    vec_t vecs[11];

    int n_total = 0;
    int n_pass  = 0;

    // stats model state (written only by the model process)
    int          n_starts;
    logic [31:0] st_si[256];
    logic [31:0] st_ei[256];
    // control of the model (written only by the main process)
    int          mdl_lat  = 0;
    int          kill_req = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Responds stat_done mdl_lat cycles after each stat_start; mean=si+10, variance=ei+7.
    initial begin : stats_model
        int cnt;
        bit act;
        int kill_seen;
        logic [31:0] si, ei;
        cnt = 0; act = 0; kill_seen = 0; n_starts = 0; si = '0; ei = '0;
        bus.stat_done = 1'b0; bus.stat_mean = '0; bus.stat_variance = '0;
        forever begin
            @(negedge Clk);
            bus.stat_done = 1'b0;
            if (kill_seen != kill_req) begin
                kill_seen = kill_req;
                act = 0;
            end else if (bus.stat_start) begin
                if (n_starts < 256) begin
                    st_si[n_starts] = bus.stat_si;
                    st_ei[n_starts] = bus.stat_ei;
                end
                n_starts++;
                si = bus.stat_si; ei = bus.stat_ei;
                act = (mdl_lat > 0); cnt = mdl_lat;
            end else if (act) begin
                cnt--;
                if (cnt == 0) begin
                    act = 0;
                    bus.stat_done = 1'b1;
                    bus.stat_mean = si + 32'd10;
                    bus.stat_variance = ei + 32'd7;
                end
            end
        end
    end

    task automatic run_job(input vec_t v, input int vn);
        int base, n_res, n_fin, n_err, hold, cyc;
        bit hs_pend, hs_last, fin_pend, busy_seen;
        logic [31:0] e;
        logic [96:0] snap;
        base = n_starts; mdl_lat = v.lat;
        n_res = 0; n_fin = 0; n_err = 0; hold = 0;
        hs_pend = 0; hs_last = 0; fin_pend = 0; busy_seen = 0; snap = '0;
        bus.cfg_len = v.len; bus.cfg_win = v.win; bus.cfg_stride = v.stride; bus.go = 1'b1;
        @(negedge Clk);
        bus.go = 1'b0;
        bus.cfg_len = 32'h5; bus.cfg_win = 32'h1; bus.cfg_stride = 32'h2;
        if (v.kind == 1) begin
            check($sformatf("v%0d cfg_err_pulse", vn), bus.cfg_err, 1);
            check($sformatf("v%0d busy_on_reject", vn), bus.busy, 0);
        end else begin
            check($sformatf("v%0d busy_start", vn), bus.busy, 1);
            check($sformatf("v%0d start_latency", vn), bus.stat_start, 1);
            check($sformatf("v%0d first_ei", vn), bus.stat_ei, v.win);
        end
        for (cyc = 0; cyc < 400; cyc++) begin
            bus.go = 1'b0;
            if (bus.busy) busy_seen = 1;
            if (bus.cfg_err) n_err++;
            if (bus.finished) n_fin++;
            if (hs_pend) begin
                hs_pend = 0;
                if (hs_last) begin
                    check($sformatf("v%0d finished_after_hs", vn), bus.finished, 1);
                    fin_pend = 1;
                end else begin
                    check($sformatf("v%0d start_after_hs", vn), bus.stat_start, 1);
                end
            end else if (fin_pend) begin
                fin_pend = 0;
                check($sformatf("v%0d busy_low_after_done", vn), bus.busy, 0);
            end
            bus.res_ready = 1'b0;
            if (bus.res_valid) begin
                if (n_res == 0 && hold < v.stall) begin
                    if (hold == 0) begin
                        snap = {bus.res_mean, bus.res_variance, bus.res_idx, bus.res_last};
                    end else begin
                        check($sformatf("v%0d res_stable", vn),
                              {bus.res_mean, bus.res_variance, bus.res_idx, bus.res_last}, snap);
                        check($sformatf("v%0d no_start_stalled", vn), bus.stat_start, 0);
                    end
                    hold++;
                    if (v.go_mid && hold == 2) begin
                        bus.go = 1'b1; bus.cfg_len = 32'd10; bus.cfg_win = 32'd2; bus.cfg_stride = 32'd1;
                    end
                end else begin
                    bus.res_ready = 1'b1;
                    check($sformatf("v%0d res_idx", vn), bus.res_idx, n_res);
                    e = v.stride * n_res + 32'd10;
                    check($sformatf("v%0d res_mean", vn), bus.res_mean, e);
                    e = v.stride * n_res + v.win + 32'd7;
                    check($sformatf("v%0d res_variance", vn), bus.res_variance, e);
                    check($sformatf("v%0d res_last", vn), bus.res_last, (n_res == v.exp_res - 1));
                    hs_pend = 1; hs_last = bus.res_last; n_res++;
                end
            end
            if (cyc > 0 && !bus.busy && !hs_pend && !fin_pend) break;
            @(negedge Clk);
        end
        bus.res_ready = 1'b0; bus.go = 1'b0;
        check($sformatf("v%0d job_ended_in_bound", vn), cyc < 400, 1);
        repeat (3) @(negedge Clk);
        check($sformatf("v%0d result_count", vn), n_res, v.exp_res);
        check($sformatf("v%0d finished_count", vn), n_fin, (v.kind == 0));
        check($sformatf("v%0d cfg_err_count", vn), n_err, (v.kind != 0));
        check($sformatf("v%0d busy_seen", vn), busy_seen, (v.kind != 1));
        check($sformatf("v%0d start_count", vn), n_starts - base, v.exp_starts);
        for (int i = 0; i < v.exp_starts && (n_starts - base) >= v.exp_starts; i++) begin
            e = v.stride * i;
            check($sformatf("v%0d win%0d_si", vn, i), st_si[base + i], e);
            e = e + v.win;
            check($sformatf("v%0d win%0d_ei", vn, i), st_ei[base + i], e);
        end
    endtask

    initial begin : main
        int bad_ev;
        vecs[0]  = '{32'd10, 32'd10, 32'd1, 12, 0, 1'b0, 0, 1, 1};
        vecs[1]  = '{32'd10, 32'd4,  32'd3, 3,  0, 1'b0, 0, 3, 3};
        vecs[2]  = '{32'd10, 32'd4,  32'd5, 5,  0, 1'b0, 0, 2, 2};
        vecs[3]  = '{32'd10, 32'd0,  32'd1, 3,  0, 1'b0, 1, 0, 0};
        vecs[4]  = '{32'd10, 32'd4,  32'd0, 3,  0, 1'b0, 1, 0, 0};
        vecs[5]  = '{32'd10, 32'd11, 32'd1, 3,  0, 1'b0, 1, 0, 0};
        vecs[6]  = '{32'd10, 32'd4,  32'd3, 4,  5, 1'b1, 0, 3, 3};
        vecs[7]  = '{32'd7,  32'd3,  32'd2, 1,  0, 1'b0, 0, 3, 3};
        vecs[8]  = '{32'hFFFF_FFFF, 32'hFFFF_FFF0, 32'h10, 2, 0, 1'b0, 0, 1, 1};
        vecs[9]  = '{32'd10, 32'd4,  32'd20, 2, 0, 1'b0, 0, 1, 1};
        vecs[10] = '{32'd10, 32'd4,  32'd3, 0,  0, 1'b0, 2, 0, 1};

        Rst = 1'b1; bus.go = 1'b0; bus.res_ready = 1'b0;
        bus.cfg_len = '0; bus.cfg_win = '0; bus.cfg_stride = '0;
        repeat (3) @(negedge Clk);
        check("rst busy", bus.busy, 0);
        check("rst finished", bus.finished, 0);
        check("rst cfg_err", bus.cfg_err, 0);
        check("rst stat_start", bus.stat_start, 0);
        check("rst stat_si", bus.stat_si, 0);
        check("rst stat_ei", bus.stat_ei, 0);
        check("rst res_valid", bus.res_valid, 0);
        check("rst res_data", {bus.res_mean, bus.res_variance, bus.res_idx, bus.res_last}, 0);
        Rst = 1'b0;
        @(negedge Clk);

        for (int v = 0; v < 11; v++) run_job(vecs[v], v);

        // reset while the stats unit is working on the first window
        mdl_lat = 12;
        bus.cfg_len = 32'd10; bus.cfg_win = 32'd4; bus.cfg_stride = 32'd3; bus.go = 1'b1;
        @(negedge Clk);
        bus.go = 1'b0;
        repeat (4) @(negedge Clk);
        check("midrst busy_before", bus.busy, 1);
        Rst = 1'b1; kill_req++;
        @(negedge Clk);
        check("midrst busy", bus.busy, 0);
        check("midrst stat_start", bus.stat_start, 0);
        check("midrst stat_idx", {bus.stat_si, bus.stat_ei}, 0);
        check("midrst res_valid", bus.res_valid, 0);
        check("midrst pulses", {bus.finished, bus.cfg_err}, 0);
        Rst = 1'b0;
        bad_ev = 0;
        repeat (20) begin
            @(negedge Clk);
            if (bus.finished || bus.cfg_err || bus.stat_start || bus.busy) bad_ev++;
        end
        check("midrst quiet_after", bad_ev, 0);
        run_job(vecs[1], 11);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/window_stat_sched.md
# window_stat_sched

Sequencer for the variance/mean statistics unit. Given a series length, window size and stride, it walks the series in sliding windows. For each window it drives the stats unit's `start`/`si`/`ei`, waits for `done`, and emits `(mean, variance, window index)` on a valid/ready result port. It sits between the predictor's top-level control and the stats datapath. The stats unit keeps its own sample-memory read port (`index`/`value`).

## Interface
- `WIDTH`, 32: width of lengths, indices and statistics.
- `TIMEOUT`, 1024: maximum cycles to wait for `stat_done` before aborting.
- `Clk`  in  1: clock; all state changes on the rising edge.
- `Rst`  in  1: reset, synchronous, active-high.
- `go`  in  1: start-of-job pulse; sampled only in IDLE.
- `cfg_len`  in  WIDTH: series length N (samples 0..N-1).
- `cfg_win`  in  WIDTH: window size W.
- `cfg_stride`  in  WIDTH: stride S between window starts.
- `busy`  out  1: high from the cycle after an accepted `go` until DONE completes.
- `finished`  out  1: one-cycle pulse when the job ends normally.
- `cfg_err`  out  1: one-cycle pulse on rejected config or timeout.
- `stat_start`  out  1: one-cycle start pulse to the stats unit.
- `stat_si`  out  WIDTH: window start index (inclusive).
- `stat_ei`  out  WIDTH: window end index (exclusive).
- `stat_done`  in  1: stats unit completion.
- `stat_mean`  in  WIDTH: mean result, valid with `stat_done`.
- `stat_variance`  in  WIDTH: variance result, valid with `stat_done`.
- `res_valid`  out  1: result available.
- `res_ready`  in  1: consumer accepts the result.
- `res_mean`, `res_variance`  out  WIDTH: captured statistics.
- `res_idx`  out  WIDTH: window number, starting at 0.
- `res_last`  out  1: this is the final window of the job.

## Operation
- States: IDLE, LAUNCH, WAIT, EMIT, DONE.
- **IDLE, `go`=1:** latch `cfg_*`.
  - Reject if W=0, S=0 or W>N: pulse `cfg_err`, stay in IDLE.
  - Otherwise set si=0, ei=W, idx=0, and go to LAUNCH.
- **LAUNCH:** `stat_start`=1 for exactly this cycle; clear the timeout counter; go to WAIT.
- **WAIT:**
  - `stat_done` is honoured only in WAIT. A `stat_done` during LAUNCH is ignored.
  - On `stat_done`: register mean and variance into `res_*`, set `res_idx`=idx, set `res_last`=(si+S+W > N), set `res_valid`=1, go to EMIT.
  - If the counter reaches TIMEOUT first: pulse `cfg_err`, drop `busy`, go to IDLE. No result is emitted.
- **EMIT:**
  - Hold all `res_*` stable while `res_valid`=1 and `res_ready`=0.
  - On handshake (`res_valid`&&`res_ready`), clear `res_valid`.
  - If `res_last`, go to DONE.
  - Otherwise set si+=S, ei=si+S+W, idx+=1, and go to LAUNCH.
- **DONE:** pulse `finished`, drop `busy`, go to IDLE.
- **Arithmetic:** the end-of-job compare si+S+W is done at WIDTH+1 bits, so wrap-around never hides the end of the job.
- **Window count:** floor((N−W)/S)+1. Trailing samples that do not fill a whole window are skipped.
- **Config stability:** `stat_si`/`stat_ei` change only when entering LAUNCH; they are stable through WAIT. Config inputs may change freely after `go` is accepted.
- **`go` while busy:** ignored.

## Timing
- **Reset values:** all outputs are 0 (`busy`, `finished`, `cfg_err`, `stat_start`, `stat_si`, `stat_ei`, `res_valid`, `res_*`). State is IDLE and the timeout counter is cleared.
- **Reset mid-job:** abort immediately. No `finished`, no `cfg_err`. `stat_start` is low from the reset cycle onward.
- **Start latency:** `go` sampled at edge k → `stat_start` high and `busy` high in cycle k+1.
- **Result latency:** `stat_done` sampled at edge j → `res_valid` high in cycle j+1.
- **Handshake:**
  - A handshake may complete in the first `res_valid` cycle.
  - After a handshake at edge h, the next `stat_start` is in cycle h+1.
  - For the last window, `finished` pulses in cycle h+1 and `busy` is low from h+2.
- **Back-pressure:** while `res_ready`=0 no new `stat_start` is issued; the stats unit is idle.
- **Timeout:** `cfg_err` pulses in the cycle after the counter reaches TIMEOUT in WAIT.

## Test plan
- **Single window:** N=10, W=10, S=1, `go` → one `stat_start` with si=0, ei=10. With a stats model returning mean=10, var=17 after 12 cycles → `res_valid` with idx=0, last=1; `finished` 1 cycle after the handshake.
- **Sliding windows:** N=10, W=4, S=3 → `stat_start` issued for (0,4), (3,7), (6,10). Results idx 0, 1, 2 with `res_last` only on idx 2. Sample 9 unused for N=10, W=4, S=5 → two windows (0,4), (5,9).
- **Bad config:** W=0; S=0; and W=11 with N=10 → each gives `cfg_err` for 1 cycle, `busy` stays 0, `stat_start` never asserted.
- **Back-pressure:** hold `res_ready`=0 for 5 cycles after the first `res_valid` → `res_*` stable, no second `stat_start`. When ready rises, `stat_start` follows on the next cycle. A `go` pulse during the job is ignored.
- **Timeout:** TIMEOUT=16, `stat_done` held low → `cfg_err` pulse, return to IDLE, no `res_valid`, no `finished`.
- **Reset mid-WAIT:** assert `Rst` for 1 cycle while waiting → all outputs 0 next cycle. A fresh `go` then runs a full job correctly.
